mbs_bus_responder: RTL and testbench

MBS_BUS_RESPONDER -- requirements
Module: mbs_bus_responder

---
 rtl/mbs_bus_pkg.sv | 21 ++
 rtl/mbs_rr_arbiter.sv | 24 ++
 rtl/mbs_bus_responder.sv | 181 ++++++++++++++++++
 tb/tb_mbs_bus_responder.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbs_bus_pkg.sv
// mbs_bus_pkg
// Shared definitions for the two-CPU bus responder:
//   - default bus widths
//   - FSM state encoding
//   - store-conditional result codes returned on rdata
package mbs_bus_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // Value returned on rdata when a store-conditional completes
    localparam int SC_OK   = 1;
    localparam int SC_FAIL = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } bus_state_t;

endpackage

// File: rtl/mbs_rr_arbiter.sv
// mbs_rr_arbiter
// Two-way round-robin selection.
//   req        : request vector, bit i from CPU i
//   last_grant : index of the CPU granted most recently
//   grant      : index of the CPU to serve (meaningful when valid = 1)
//   valid      : at least one request is pending
// A lone requester always wins; on a tie the CPU not granted last wins.
module mbs_rr_arbiter (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |req;
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else begin
            grant = req[1];
        end
    end

endmodule

// File: rtl/mbs_bus_responder.sv
// mbs_bus_responder
// Serves read / write / load-linked / store-conditional accesses from two
// CPUs onto one synchronous SRAM port, one access at a time.
//
// Handshake: a CPU raises req_i with its fields and holds everything stable
// until ack_i pulses for one cycle; the access completes in that cycle and
// rdata is valid only while ack_i is high. cpu_pause[i] = req_i & ~ack_i.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req/we/ll/sc/addr/wdata 0,1 per-CPU request fields
//   ack0, ack1, rdata           completion pulse and read data / SC result
//   cpu_pause                   per-CPU stall
//   cpu_sel                     CPU currently (or last) granted
//   mem_re/mem_we/mem_addr/mem_wdata/mem_rdata   SRAM port (1-cycle read)
//   lock_flag, lock_addr0/1     LL/SC reservation state
//   fsm_state                   current FSM state, for observation
//
// Each access takes IDLE -> ACCESS -> RESP: strobe in ACCESS, ack in RESP.
module mbs_bus_responder
    import mbs_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              ll0,
    input  logic              ll1,
    input  logic              sc0,
    input  logic              sc1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        cpu_pause,
    output logic              cpu_sel,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        lock_flag,
    output logic [ADDR_W-1:0] lock_addr0,
    output logic [ADDR_W-1:0] lock_addr1,
    output logic [1:0]        fsm_state
);

    bus_state_t        state_q, state_d;
    logic              sel_q;
    logic              last_q;
    logic              we_q, ll_q, sc_q;
    logic              sc_ok_q;
    logic [ADDR_W-3:0] word_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        lock_flag_q;
    logic [ADDR_W-1:0] lock_addr0_q, lock_addr1_q;

    logic              grant, any_req;
    logic [ADDR_W-1:0] word_addr;
    logic [ADDR_W-1:0] own_lock_addr;
    logic              sc_pass;
    logic              wrote;
    logic              is_ll;
    logic              unused_low;

    // Byte-offset bits never select anything on a word-wide bus
    assign unused_low = ^{addr0[1:0], addr1[1:0]};

    mbs_rr_arbiter u_arb (
        .req        ({req1, req0}),
        .last_grant (last_q),
        .grant      (grant),
        .valid      (any_req)
    );

    assign word_addr     = {word_q, 2'b00};
    assign own_lock_addr = sel_q ? lock_addr1_q : lock_addr0_q;
    assign sc_pass       = lock_flag_q[sel_q] & (own_lock_addr == word_addr);
    // SC is decided in ACCESS and remembered for RESP, where rdata reports it
    assign wrote         = sc_q ? sc_ok_q : we_q;
    assign is_ll         = ll_q & ~we_q & ~sc_q;

    always_comb begin
        state_d = state_q;
        mem_re  = 1'b0;
        mem_we  = 1'b0;
        ack0    = 1'b0;
        ack1    = 1'b0;
        rdata   = '0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                if (sc_q) begin
                    mem_we = sc_pass;
                end else if (we_q) begin
                    mem_we = 1'b1;
                end else begin
                    mem_re = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                ack0    = ~sel_q;
                ack1    = sel_q;
                if (sc_q) begin
                    rdata = sc_ok_q ? DATA_W'(SC_OK) : DATA_W'(SC_FAIL);
                end else if (!we_q) begin
                    rdata = mem_rdata;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sel_q        <= 1'b0;
            last_q       <= 1'b1;
            we_q         <= 1'b0;
            ll_q         <= 1'b0;
            sc_q         <= 1'b0;
            sc_ok_q      <= 1'b0;
            word_q       <= '0;
            wdata_q      <= '0;
            lock_flag_q  <= 2'b00;
            lock_addr0_q <= '0;
            lock_addr1_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && any_req) begin
                sel_q   <= grant;
                last_q  <= grant;
                we_q    <= grant ? we1 : we0;
                ll_q    <= grant ? ll1 : ll0;
                sc_q    <= grant ? sc1 : sc0;
                word_q  <= grant ? addr1[ADDR_W-1:2] : addr0[ADDR_W-1:2];
                wdata_q <= grant ? wdata1 : wdata0;
            end
            if (state_q == ST_ACCESS) begin
                sc_ok_q <= sc_q & sc_pass;
            end
            // Reservations change once the access is complete
            if (state_q == ST_RESP) begin
                if (wrote) begin
                    if (lock_addr0_q == word_addr) lock_flag_q[0] <= 1'b0;
                    if (lock_addr1_q == word_addr) lock_flag_q[1] <= 1'b0;
                end else if (is_ll) begin
                    if (sel_q) begin
                        lock_flag_q[1] <= 1'b1;
                        lock_addr1_q   <= word_addr;
                    end else begin
                        lock_flag_q[0] <= 1'b1;
                        lock_addr0_q   <= word_addr;
                    end
                end
            end
        end
    end

    assign cpu_pause  = {req1 & ~ack1, req0 & ~ack0};
    assign cpu_sel    = sel_q;
    assign mem_addr   = word_addr;
    assign mem_wdata  = wdata_q;
    assign lock_flag  = lock_flag_q;
    assign lock_addr0 = lock_addr0_q;
    assign lock_addr1 = lock_addr1_q;
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_mbs_bus_responder.sv
// tb_mbs_bus_responder
// Directed table of single accesses, hand-written multi-cycle sequences
// (tie arbitration, SC race, reset during an access), then random traffic
// from both CPUs against a transaction-level reference model.
module tb_mbs_bus_responder;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_v, we_v, ll_v, sc_v;
    logic [31:0] addr_v [2];
    logic [31:0] wdata_v [2];
    logic        ack0, ack1;
    logic [31:0] rdata;
    logic [1:0]  cpu_pause;
    logic        cpu_sel;
    logic        mem_re, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  lock_flag;
    logic [31:0] lock_addr0, lock_addr1;
    logic [1:0]  fsm_state;

    int n_checks = 0;
    int n_err    = 0;

    mbs_bus_responder #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req_v[0]), .req1(req_v[1]),
        .we0(we_v[0]), .we1(we_v[1]),
        .ll0(ll_v[0]), .ll1(ll_v[1]),
        .sc0(sc_v[0]), .sc1(sc_v[1]),
        .addr0(addr_v[0]), .addr1(addr_v[1]),
        .wdata0(wdata_v[0]), .wdata1(wdata_v[1]),
        .ack0(ack0), .ack1(ack1), .rdata(rdata),
        .cpu_pause(cpu_pause), .cpu_sel(cpu_sel),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .lock_flag(lock_flag), .lock_addr0(lock_addr0), .lock_addr1(lock_addr1),
        .fsm_state(fsm_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- SRAM environment (with preload port) ----------------
    logic [31:0] sram [256];
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) sram[pl_idx] <= pl_data;
        else if (mem_we) sram[mem_addr[9:2]] <= mem_wdata;
        if (mem_re) mem_rdata <= sram[mem_addr[9:2]];
    end

    // ---------------- reference model state ----------------
    logic [31:0] ref_mem [256];
    logic [1:0]  m_lf;
    logic [31:0] m_la [2];

    typedef struct {
        int          cyc;
        int          cpu;
        logic [31:0] rd;
        logic [1:0]  lf;
        logic [31:0] la0;
        logic [31:0] la1;
    } exp_t;
    exp_t exp_q[$];

    function automatic void m_write(input logic [31:0] w, input logic [31:0] wd);
        ref_mem[w[9:2]] = wd;
        for (int j = 0; j < 2; j++) if (m_la[j] == w) m_lf[j] = 1'b0;
    endfunction

    // op: 0 read, 1 load-linked, 2 write, 3 store-conditional
    function automatic logic [31:0] m_exec(input int cpu, input int op,
                                           input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] w;
        logic [31:0] r;
        w = addr & 32'hFFFF_FFFC;
        r = 32'h0;
        case (op)
            0: r = ref_mem[w[9:2]];
            1: begin r = ref_mem[w[9:2]]; m_lf[cpu] = 1'b1; m_la[cpu] = w; end
            2: m_write(w, wd);
            default: if (m_lf[cpu] && m_la[cpu] == w) begin m_write(w, wd); r = 32'h1; end
        endcase
        return r;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic clear_inputs();
        req_v = 2'b00; we_v = 2'b00; ll_v = 2'b00; sc_v = 2'b00;
        addr_v[0] = '0; addr_v[1] = '0; wdata_v[0] = '0; wdata_v[1] = '0;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic set_cpu(input int cpu, input bit we, input bit ll, input bit sc,
                           input logic [31:0] addr, input logic [31:0] wd);
        we_v[cpu] = we; ll_v[cpu] = ll; sc_v[cpu] = sc;
        addr_v[cpu] = addr; wdata_v[cpu] = wd; req_v[cpu] = 1'b1;
    endtask

    // One isolated access from one CPU, checked end to end
    task automatic run_one(input int cpu, input bit we, input bit ll, input bit sc,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input logic [1:0] exp_lf,
                           input string nm);
        int n, lat;
        bit got, saw_re, saw_we, exp_w;
        logic [31:0] rd, wd_seen, ad_seen;
        @(negedge clk);
        set_cpu(cpu, we, ll, sc, addr, wd);
        n = 0; lat = -1; got = 0; saw_re = 0; saw_we = 0;
        rd = '0; wd_seen = '0; ad_seen = '0;
        while (!got && n < 8) begin
            @(negedge clk);
            n++;
            if (n == 1) chk({nm, " pause"}, 32'(cpu_pause), 32'(2'b01 << cpu));
            if (mem_re || mem_we) ad_seen = mem_addr;
            if (mem_re) saw_re = 1;
            if (mem_we) begin saw_we = 1; wd_seen = mem_wdata; end
            if ((cpu == 0 && ack0) || (cpu == 1 && ack1)) begin
                got = 1; lat = n; rd = rdata;
            end
        end
        clear_inputs();
        exp_w = sc ? (exp_rd == 32'h1) : we;
        chk({nm, " latency"}, lat, 2);
        chk({nm, " rdata"}, rd, exp_rd);
        chk({nm, " mem_we"}, 32'(saw_we), 32'(exp_w));
        chk({nm, " mem_re"}, 32'(saw_re), 32'(!we && !sc));
        if (saw_re || saw_we) chk({nm, " mem_addr"}, ad_seen, addr & 32'hFFFF_FFFC);
        if (exp_w) chk({nm, " mem_wdata"}, wd_seen, wd);
        @(negedge clk);
        chk({nm, " lock_flag"}, 32'(lock_flag), 32'(exp_lf));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int          cpu;
        bit          we;
        bit          ll;
        bit          sc;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [1:0]  exp_lf;
    } vec_t;
    vec_t vt [11];

    initial begin
        int a0, a1;
        logic s0, s1;
        logic [31:0] r0, r1;
        bit got;

        vt[0]  = '{0, 0, 0, 0, 32'h100, 32'h0,  32'hDEADBEEF, 2'b00};
        vt[1]  = '{0, 0, 1, 0, 32'h200, 32'h0,  32'h11112222, 2'b01};
        vt[2]  = '{0, 1, 0, 1, 32'h200, 32'h5,  32'h1,        2'b00};
        vt[3]  = '{0, 0, 0, 0, 32'h200, 32'h0,  32'h5,        2'b00};
        vt[4]  = '{0, 0, 1, 0, 32'h200, 32'h0,  32'h5,        2'b01};
        vt[5]  = '{1, 1, 0, 0, 32'h200, 32'h77, 32'h0,        2'b00};
        vt[6]  = '{0, 1, 0, 1, 32'h200, 32'h99, 32'h0,        2'b00};
        vt[7]  = '{0, 0, 0, 0, 32'h202, 32'h0,  32'h77,       2'b00};
        vt[8]  = '{1, 0, 1, 0, 32'h104, 32'h0,  32'hCAFEF00D, 2'b10};
        vt[9]  = '{1, 1, 0, 1, 32'h108, 32'hAA, 32'h0,        2'b10};
        vt[10] = '{0, 1, 0, 0, 32'h104, 32'h1,  32'h0,        2'b00};

        rst_n = 1'b0;
        pl_en = 1'b0; pl_idx = '0; pl_data = '0;
        clear_inputs();
        preload(8'h40, 32'hDEADBEEF);   // 0x100
        preload(8'h41, 32'hCAFEF00D);   // 0x104
        preload(8'h80, 32'h11112222);   // 0x200
        preload(8'hC0, 32'h33333333);   // 0x300

        // Reset values while held in reset
        #1;
        chk("rst ack0", 32'(ack0), 0);
        chk("rst ack1", 32'(ack1), 0);
        chk("rst mem_re", 32'(mem_re), 0);
        chk("rst mem_we", 32'(mem_we), 0);
        chk("rst rdata", rdata, 0);
        chk("rst cpu_sel", 32'(cpu_sel), 0);
        chk("rst lock_flag", 32'(lock_flag), 0);
        chk("rst lock_addr0", lock_addr0, 0);
        chk("rst lock_addr1", lock_addr1, 0);
        chk("rst state", 32'(fsm_state), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Tie right after reset: CPU0 first, CPU1 three cycles later
        @(negedge clk);
        set_cpu(0, 0, 0, 0, 32'h100, 0);
        set_cpu(1, 0, 0, 0, 32'h104, 0);
        a0 = -1; a1 = -1; s0 = 1'bx; s1 = 1'bx; r0 = 'x; r1 = 'x;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (ack0 && a0 < 0) begin a0 = n; s0 = cpu_sel; r0 = rdata; req_v[0] = 1'b0; end
            if (ack1 && a1 < 0) begin a1 = n; s1 = cpu_sel; r1 = rdata; req_v[1] = 1'b0; end
        end
        clear_inputs();
        chk("tie ack0 cycle", a0, 2);
        chk("tie ack1 cycle", a1, 5);
        chk("tie sel first", 32'(s0), 0);
        chk("tie sel second", 32'(s1), 1);
        chk("tie rdata0", r0, 32'hDEADBEEF);
        chk("tie rdata1", r1, 32'hCAFEF00D);
        chk("tie sel held idle", 32'(cpu_sel), 1);

        for (int i = 0; i < 11; i++)
            run_one(vt[i].cpu, vt[i].we, vt[i].ll, vt[i].sc, vt[i].addr, vt[i].wd,
                    vt[i].exp_rd, vt[i].exp_lf, $sformatf("vec%0d", i));
        chk("lock_addr0 kept", lock_addr0, 32'h200);
        chk("lock_addr1 kept", lock_addr1, 32'h104);

        // Both CPUs reserve 0x300, then race with SC in the same cycle
        run_one(0, 0, 1, 0, 32'h300, 0, 32'h33333333, 2'b01, "race ll0");
        run_one(1, 0, 1, 0, 32'h300, 0, 32'h33333333, 2'b11, "race ll1");
        @(negedge clk);
        set_cpu(0, 1, 0, 1, 32'h300, 32'hA0);
        set_cpu(1, 1, 0, 1, 32'h300, 32'hB0);
        a0 = -1; a1 = -1; r0 = 'x; r1 = 'x;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (ack0 && a0 < 0) begin a0 = n; r0 = rdata; req_v[0] = 1'b0; end
            if (ack1 && a1 < 0) begin a1 = n; r1 = rdata; req_v[1] = 1'b0; end
        end
        clear_inputs();
        chk("race ack0 cycle", a0, 2);
        chk("race ack1 cycle", a1, 5);
        chk("race sc0 result", r0, 1);
        chk("race sc1 result", r1, 0);
        chk("race lock_flag", 32'(lock_flag), 0);
        run_one(1, 0, 0, 0, 32'h300, 0, 32'hA0, 2'b00, "race readback");

        // Reset in the middle of an access; the request is kept and completes
        @(negedge clk);
        set_cpu(0, 0, 0, 0, 32'h100, 0);
        @(negedge clk);
        chk("abort mem_re", 32'(mem_re), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort mem_re rst", 32'(mem_re), 0);
        chk("abort ack0 rst", 32'(ack0), 0);
        chk("abort state rst", 32'(fsm_state), 0);
        chk("abort cpu_sel rst", 32'(cpu_sel), 0);
        @(negedge clk);
        chk("abort no ack", 32'(ack0), 0);
        rst_n = 1'b1;
        a0 = -1; r0 = 'x;
        for (int n = 1; n <= 8 && a0 < 0; n++) begin
            @(negedge clk);
            if (ack0) begin a0 = n; r0 = rdata; end
        end
        clear_inputs();
        chk("reissue ack cycle", a0, 2);
        chk("reissue rdata", r0, 32'hDEADBEEF);

        // ---------------- random traffic ----------------
        do_reset();
        for (int i = 0; i < 256; i++) begin
            logic [31:0] v;
            v = $urandom;
            ref_mem[i] = v;
            preload(8'(i), v);
        end
        m_lf = 2'b00; m_la[0] = '0; m_la[1] = '0;
        begin
            int free_cyc, lf_chk_cyc, rr_last;
            int r_op [2];
            logic [1:0]  exp_ack, lf_exp;
            logic [31:0] la0_exp, la1_exp;
            logic [31:0] addr_set [4];
            exp_t e;
            addr_set[0] = 32'h100; addr_set[1] = 32'h104;
            addr_set[2] = 32'h200; addr_set[3] = 32'h300;
            free_cyc = 0; lf_chk_cyc = -1; rr_last = 1;
            lf_exp = 0; la0_exp = 0; la1_exp = 0;
            r_op[0] = 0; r_op[1] = 0;
            for (int t = 0; t < 620; t++) begin
                @(negedge clk);
                while (exp_q.size() > 0 && exp_q[0].cyc < t) void'(exp_q.pop_front());
                exp_ack = 2'b00;
                if (exp_q.size() > 0 && exp_q[0].cyc == t) exp_ack[exp_q[0].cpu] = 1'b1;
                chk($sformatf("rnd ack t%0d", t), 32'({ack1, ack0}), 32'(exp_ack));
                chk($sformatf("rnd pause t%0d", t), 32'(cpu_pause), 32'(req_v & ~exp_ack));
                if (exp_ack != 0) begin
                    e = exp_q.pop_front();
                    chk($sformatf("rnd rdata t%0d", t), rdata, e.rd);
                    lf_chk_cyc = t + 1; lf_exp = e.lf; la0_exp = e.la0; la1_exp = e.la1;
                end
                if (t == lf_chk_cyc) begin
                    chk($sformatf("rnd lock_flag t%0d", t), 32'(lock_flag), 32'(lf_exp));
                    chk($sformatf("rnd lock_addr0 t%0d", t), lock_addr0, la0_exp);
                    chk($sformatf("rnd lock_addr1 t%0d", t), lock_addr1, la1_exp);
                end
                for (int c = 0; c < 2; c++) begin
                    if (exp_ack[c]) begin
                        req_v[c] = 1'b0; we_v[c] = 0; ll_v[c] = 0; sc_v[c] = 0;
                    end
                    if (!req_v[c] && t < 600 && $urandom_range(0, 2) == 0) begin
                        r_op[c] = $urandom_range(0, 3);
                        set_cpu(c, r_op[c] >= 2, r_op[c] == 1, r_op[c] == 3,
                                addr_set[$urandom_range(0, 3)] | 32'($urandom_range(0, 3)),
                                $urandom);
                    end
                end
                if (t >= free_cyc && req_v != 2'b00) begin
                    int g;
                    g = (req_v == 2'b11) ? 1 - rr_last : (req_v[1] ? 1 : 0);
                    e.cyc = t + 2;
                    e.cpu = g;
                    e.rd  = m_exec(g, r_op[g], addr_v[g], wdata_v[g]);
                    e.lf  = m_lf;
                    e.la0 = m_la[0];
                    e.la1 = m_la[1];
                    exp_q.push_back(e);
                    free_cyc = t + 3;
                    rr_last = g;
                end
            end
            got = (exp_q.size() == 0);
            chk("rnd drain", 32'(got), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
